alu_req_arbiter: RTL and testbench

- Shares the single ALU/register-file controller among NUM_REQ requesters.
- Round-robin arbitration; each granted 12-bit command is forwarded to the controller over a valid/ready issue handshake, then the block waits for completion and returns result and flags to the owner.
- A requester may hold a lock across consecutive commands, so a read-modify-write sequence (e.g. CAS followed by a flag check) is not interleaved with other requesters' commands.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_req_arbiter_rr_pick.sv | 29 ++
 rtl/alu_req_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU request arbiter and related blocks.
package alu_pkg;

    // 12-bit controller command: {op, a1, a2, a3}
    typedef struct packed {
        logic [2:0] op;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [2:0] a3;
    } cmd_t;

    // Result flags as returned by the controller
    typedef struct packed {
        logic o;
        logic c;
        logic z;
        logic n;
    } flags_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CAS = 3'b111;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

endpackage

// File: rtl/alu_req_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          valid
);

    // Scan N positions starting at ptr; keep the first hit only
    always_comb begin
        int j;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                idx       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU controller among NUM_REQ requesters,
// with optional lock so an owner can chain commands without interleaving.
module alu_req_arbiter import alu_pkg::*; #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    lock,
    input  logic [NUM_REQ*12-1:0] cmd_in,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_y,
    output logic [3:0]            resp_flags,
    output logic [11:0]           ctl_cmd,
    output logic                  ctl_valid,
    input  logic                  ctl_ready,
    input  logic                  ctl_done,
    input  logic [31:0]           ctl_y,
    input  logic [3:0]            ctl_flags
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_t           state_q, state_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        own_q, own_d;
    logic [CW-1:0]        lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [31:0]          resp_y_q, resp_y_d;
    flags_t               resp_flags_q, resp_flags_d;
    cmd_t                 ctl_cmd_q, ctl_cmd_d;
    logic                 ctl_valid_q, ctl_valid_d;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [PW-1:0]        pick_idx;
    logic                 pick_valid;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Next-state and output decode for the arbitration FSM
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        own_d        = own_q;
        lock_cnt_d   = lock_cnt_q;
        gnt_d        = gnt_q;
        resp_valid_d = '0;
        resp_y_d     = resp_y_q;
        resp_flags_d = resp_flags_q;
        ctl_cmd_d    = ctl_cmd_q;
        ctl_valid_d  = ctl_valid_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    own_d       = pick_idx;
                    gnt_d       = pick_onehot;
                    ctl_cmd_d   = cmd_t'(cmd_in[int'(pick_idx)*12 +: 12]);
                    ctl_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (ctl_valid_q && ctl_ready) begin
                    ctl_valid_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (ctl_done) begin
                    resp_y_d     = ctl_y;
                    resp_flags_d = flags_t'(ctl_flags);
                    resp_valid_d = gnt_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                // A locked owner chains directly back into ISSUE until its budget runs out
                if (lock[own_q] && req[own_q] && (lock_cnt_q < CW'(MAX_LOCK - 1))) begin
                    lock_cnt_d  = lock_cnt_q + CW'(1);
                    ctl_cmd_d   = cmd_t'(cmd_in[int'(own_q)*12 +: 12]);
                    ctl_valid_d = 1'b1;
                    state_d     = ISSUE;
                end else begin
                    gnt_d      = '0;
                    lock_cnt_d = '0;
                    rr_ptr_d   = (own_q == PW'(NUM_REQ - 1)) ? '0 : own_q + PW'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            own_q        <= '0;
            lock_cnt_q   <= '0;
            gnt_q        <= '0;
            resp_valid_q <= '0;
            resp_y_q     <= '0;
            resp_flags_q <= '0;
            ctl_cmd_q    <= '0;
            ctl_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            own_q        <= own_d;
            lock_cnt_q   <= lock_cnt_d;
            gnt_q        <= gnt_d;
            resp_valid_q <= resp_valid_d;
            resp_y_q     <= resp_y_d;
            resp_flags_q <= resp_flags_d;
            ctl_cmd_q    <= ctl_cmd_d;
            ctl_valid_q  <= ctl_valid_d;
        end
    end

    assign gnt        = gnt_q;
    assign resp_valid = resp_valid_q;
    assign resp_y     = resp_y_q;
    assign resp_flags = resp_flags_q;
    assign ctl_cmd    = ctl_cmd_q;
    assign ctl_valid  = ctl_valid_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: behavioural model compared every cycle plus
// directed scenarios with literal expectations.
module tb_alu_req_arbiter;

    localparam int N  = 4;
    localparam int ML = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  lock = '0;
    logic [N*12-1:0] cmd_in = '0;
    logic [N-1:0]  gnt, resp_valid;
    logic [31:0]   resp_y;
    logic [3:0]    resp_flags;
    logic [11:0]   ctl_cmd;
    logic          ctl_valid;
    logic          ctl_ready = 1'b1;
    logic          ctl_done = 1'b0;
    logic [31:0]   ctl_y = '0;
    logic [3:0]    ctl_flags = '0;

    alu_req_arbiter #(.NUM_REQ(N), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .cmd_in(cmd_in),
        .gnt(gnt), .resp_valid(resp_valid), .resp_y(resp_y), .resp_flags(resp_flags),
        .ctl_cmd(ctl_cmd), .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
        .ctl_done(ctl_done), .ctl_y(ctl_y), .ctl_flags(ctl_flags)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 free, 1 command offered, 2 awaiting completion, 3 reporting
    int          m_ph = 0, m_own = -1, m_ptr = 0, m_cnt = 0, m_rv = -1;
    logic [11:0] m_cmd = '0;
    logic        m_val = 1'b0;
    logic [31:0] m_y = '0;
    logic [3:0]  m_fl = '0;

    always @(posedge clk) begin
        int rvn;
        if (rst) begin
            m_ph = 0; m_own = -1; m_ptr = 0; m_cnt = 0; m_rv = -1;
            m_cmd = '0; m_val = 1'b0; m_y = '0; m_fl = '0;
        end else begin
            rvn = -1;
            case (m_ph)
                0: begin
                    for (int k = 0; k < N; k++)
                        if (m_own < 0 && req[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
                    if (m_own >= 0) begin
                        m_cmd = cmd_in[12*m_own +: 12]; m_val = 1'b1; m_ph = 1;
                    end
                end
                1: if (ctl_ready) begin m_val = 1'b0; m_ph = 2; end
                2: if (ctl_done) begin m_y = ctl_y; m_fl = ctl_flags; rvn = m_own; m_ph = 3; end
                default: begin
                    if (lock[m_own] && req[m_own] && m_cnt + 1 < ML) begin
                        m_cnt++; m_cmd = cmd_in[12*m_own +: 12]; m_val = 1'b1; m_ph = 1;
                    end else begin
                        m_ptr = (m_own + 1) % N; m_own = -1; m_cnt = 0; m_ph = 0;
                    end
                end
            endcase
            m_rv = rvn;
        end
    end

    // Compare every cycle once reset has been applied
    always @(negedge clk) begin
        logic [3:0] eg, er;
        if (chk_en) begin
            eg = (m_own >= 0) ? 4'(1 << m_own) : 4'd0;
            er = (m_rv  >= 0) ? 4'(1 << m_rv)  : 4'd0;
            check("cycle_model", {gnt, resp_valid, ctl_valid, ctl_cmd, resp_y, resp_flags},
                  {eg, er, m_val, m_cmd, m_y, m_fl});
        end
    end

    // Observation of grant sequence and responses
    int          obs_gnt[$];
    int          rv_cnt[N];
    logic [N-1:0] prev_gnt = '0;
    always @(negedge clk) begin
        if (gnt != 0 && gnt != prev_gnt) obs_gnt.push_back(int'(gnt));
        prev_gnt = gnt;
        for (int i = 0; i < N; i++) if (resp_valid[i]) rv_cnt[i]++;
    end

    function automatic int obs_at(int i);
        return (i < obs_gnt.size()) ? obs_gnt[i] : -1;
    endfunction

    // ---------------- controller emulation ----------------
    int          dly = 1;
    int          pend = 0;
    bit          armed = 0;
    int          hs_cnt = 0;
    logic [31:0] cy = 32'h0;
    logic [3:0]  cf = 4'h0;
    initial begin
        bit hs;
        forever begin
            @(posedge clk);
            hs = ctl_valid && ctl_ready && !rst;
            @(negedge clk);
            ctl_done = 1'b0;
            if (hs) begin pend = dly; armed = 1; hs_cnt++; end
            else if (pend > 0) pend--;
            if (armed && pend == 0) begin
                ctl_done = 1'b1; ctl_y = cy; ctl_flags = cf; armed = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; lock = '0;
        tick(2);
        check("reset_state", {gnt, resp_valid, ctl_valid, ctl_cmd, resp_y, resp_flags}, 64'd0);
        rst = 1'b0;
    endtask

    task automatic wait_resp(int who);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid[who]) break;
        end
        check($sformatf("resp_seen_%0d", who), 64'(i < 100), 64'd1);
    endtask

    task automatic wait_gnt(logic [N-1:0] v);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gnt == v) break;
        end
        check("gnt_seen", 64'(i < 100), 64'd1);
    endtask

    task automatic wait_obs(int n);
        int i;
        for (i = 0; i < 300; i++) begin
            if (obs_gnt.size() >= n) break;
            @(negedge clk);
        end
        check("grants_seen", 64'(i < 300), 64'd1);
    endtask

    task automatic wait_valid_low;
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ctl_valid) break;
        end
        check("accept_seen", 64'(i < 100), 64'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int base;
        bit ok;
        @(posedge clk); #1; chk_en = 1;
        @(negedge clk);

        // Single request, then rr_ptr moves past the owner
        do_reset;
        dly = 1; cy = 32'h1234; cf = 4'b0010;
        cmd_in[12 +: 12] = 12'h053; req = 4'b0010;
        tick(1);
        check("t1_cmd", {gnt, ctl_valid, ctl_cmd}, {4'b0010, 1'b1, 12'h053});
        wait_resp(1);
        req = '0;
        check("t1_y", resp_y, 32'h1234);
        check("t1_flags", resp_flags, 4'b0010);
        tick(1);
        check("t1_release", {gnt, resp_valid}, 64'd0);
        obs_gnt.delete(); req = 4'b0101;
        wait_obs(1);
        check("t1_rrptr", obs_at(0), 64'd4);
        req = '0; tick(12);

        // All requesting, no lock: strict rotation
        do_reset;
        obs_gnt.delete(); req = 4'b1111;
        wait_obs(5);
        req = '0;
        check("t2_g0", obs_at(0), 64'd1);
        check("t2_g1", obs_at(1), 64'd2);
        check("t2_g2", obs_at(2), 64'd4);
        check("t2_g3", obs_at(3), 64'd8);
        check("t2_g4", obs_at(4), 64'd1);
        tick(12);

        // Lock: requester 2 chains MAX_LOCK commands, then 0 gets the bus
        do_reset;
        obs_gnt.delete(); for (int i = 0; i < N; i++) rv_cnt[i] = 0;
        cmd_in[24 +: 12] = 12'h2A1; lock = 4'b0100; req = 4'b0100;
        wait_gnt(4'b0100);
        req = 4'b0101;
        wait_obs(2);
        check("t3_first", obs_at(0), 64'd4);
        check("t3_next", obs_at(1), 64'd1);
        check("t3_count", rv_cnt[2], 64'(ML));
        req = '0; lock = '0; tick(12);

        // Backpressure: command held while owner drops req and changes cmd
        do_reset;
        base = hs_cnt; ctl_ready = 1'b0;
        cmd_in[12 +: 12] = 12'h0A5; req = 4'b0010;
        tick(1);
        req = '0; cmd_in[12 +: 12] = 12'hFFF;
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (!(ctl_valid && ctl_cmd == 12'h0A5)) ok = 0;
        end
        check("t4_hold", {ok, ctl_cmd}, {1'b1, 12'h0A5});
        ctl_ready = 1'b1;
        wait_resp(1);
        tick(5);
        check("t4_issues", hs_cnt - base, 64'd1);
        tick(6);

        // Reset during WAIT, stray done afterwards is ignored
        do_reset;
        dly = 6; for (int i = 0; i < N; i++) rv_cnt[i] = 0;
        cmd_in[12 +: 12] = 12'h111; req = 4'b0010;
        wait_gnt(4'b0010);
        req = '0;
        wait_valid_low;
        rst = 1'b1;
        tick(1);
        check("t5_abort", {gnt, resp_valid, ctl_valid, ctl_cmd, resp_y, resp_flags}, 64'd0);
        rst = 1'b0;
        tick(10);
        check("t5_no_resp", rv_cnt[1], 64'd0);
        dly = 1; obs_gnt.delete(); req = 4'b1111;
        wait_obs(1);
        check("t5_ptr0", obs_at(0), 64'd1);
        req = '0; tick(14);

        // CAS opcode passes through untouched
        do_reset;
        cy = 32'hCAFE0001; cf = 4'b0010;
        cmd_in[36 +: 12] = 12'hE53; req = 4'b1000;
        tick(1);
        check("t6_cmd", {gnt, ctl_valid, ctl_cmd}, {4'b1000, 1'b1, 12'hE53});
        wait_resp(3);
        req = '0;
        check("t6_flags", resp_flags, 4'b0010);
        check("t6_y", resp_y, 32'hCAFE0001);
        tick(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
